cdc_toggle_monitor: RTL and testbench

//  Bclk-domain consumer of the toggle stream leaving the 3-FF CDC data sink (Dout).
//  It detects every transition on Din and measures the gap in Bclk cycles between transitions.

---
 rtl/cdc_toggle_monitor_pkg.sv | 15 +
 rtl/cdc_toggle_monitor_if.sv | 16 +
 rtl/cdc_toggle_monitor_edge_det.sv | 19 +
 rtl/cdc_toggle_monitor.sv | 129 ++++++++++++
 tb/tb_cdc_toggle_monitor.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/cdc_toggle_monitor_pkg.sv
// Shared constants for the Bclk-domain toggle monitor: FSM encodings and default parameters.
package cdc_toggle_monitor_pkg;

  localparam int unsigned DEF_INTW    = 8;
  localparam int unsigned DEF_CNTW    = 16;
  localparam int unsigned DEF_MIN_GAP = 2;
  localparam int unsigned DEF_MAX_GAP = 200;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_TRACK = 2'd1,
    ST_STALL = 2'd2
  } monState_t;

endpackage

// File: rtl/cdc_toggle_monitor_if.sv
// Event record handshake between the toggle monitor (master) and its downstream reader (slave).
interface cdc_toggle_monitor_if
  import cdc_toggle_monitor_pkg::*;
#(
  parameter int unsigned INTW = DEF_INTW
) ();

  logic            evt_valid;
  logic            evt_ready;
  logic [INTW-1:0] evt_interval;
  logic            evt_level;

  modport master (output evt_valid, output evt_interval, output evt_level, input evt_ready);
  modport slave  (input evt_valid, input evt_interval, input evt_level, output evt_ready);

endinterface

// File: rtl/cdc_toggle_monitor_edge_det.sv
// Transition detector on the synchronised toggle line; din_q tracks Din every cycle,
// including during reset, so the first post-reset cycle never sees a false edge.
module toggle_edge_det (
  input  logic Bclk,
  input  logic Din,
  output logic edge_c,
  output logic level_c
);

  logic dinQ;

  always_ff @(posedge Bclk) begin
    dinQ <= Din;
  end

  assign edge_c  = Din ^ dinQ;
  assign level_c = Din;

endmodule

// File: rtl/cdc_toggle_monitor.sv
// Measures Bclk gaps between Din transitions, hands each gap to a 1-entry valid/ready
// buffer and raises sticky flags for short gaps, stalls and dropped events.
module cdc_toggle_monitor
  import cdc_toggle_monitor_pkg::*;
#(
  parameter int unsigned INTW    = DEF_INTW,
  parameter int unsigned CNTW    = DEF_CNTW,
  parameter int unsigned MIN_GAP = DEF_MIN_GAP,
  parameter int unsigned MAX_GAP = DEF_MAX_GAP
) (
  input  logic                 Bclk,
  input  logic                 reset,
  input  logic                 Din,
  input  logic                 clr_err,
  cdc_toggle_monitor_if.master evt,
  output logic [CNTW-1:0]      edge_count,
  output logic                 err_short,
  output logic                 err_stall,
  output logic                 err_overflow
);

  localparam logic [INTW-1:0] GAP_SAT    = '1;
  localparam logic [CNTW-1:0] CNT_SAT    = '1;
  localparam logic [INTW-1:0] MIN_GAP_W  = INTW'(MIN_GAP);
  localparam logic [INTW:0]   MAX_GAP_W  = (INTW+1)'(MAX_GAP);

  logic            edge_c;
  logic            level_c;
  monState_t       state;
  monState_t       stateNxt_c;
  logic            emit_c;
  logic            setShort_c;
  logic            setStall_c;
  logic [INTW-1:0] gapCnt;
  logic [INTW:0]   gapInc_c;

  toggle_edge_det uEdgeDet (
    .Bclk    (Bclk),
    .Din     (Din),
    .edge_c  (edge_c),
    .level_c (level_c)
  );

  // One bit wider so the stall compare cannot wrap when MAX_GAP is the saturation value.
  assign gapInc_c = (INTW+1)'(gapCnt) + (INTW+1)'(1);

  always_ff @(posedge Bclk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= stateNxt_c;
    end
  end

  always_comb begin
    stateNxt_c = state;
    emit_c     = 1'b0;
    setShort_c = 1'b0;
    setStall_c = 1'b0;
    case (state)
      ST_IDLE: begin
        // First transition only establishes the reference point.
        if (edge_c) stateNxt_c = ST_TRACK;
      end
      ST_TRACK: begin
        if (edge_c) begin
          emit_c     = 1'b1;
          setShort_c = (gapCnt < MIN_GAP_W);
        end else if (gapInc_c == MAX_GAP_W) begin
          stateNxt_c = ST_STALL;
          setStall_c = 1'b1;
        end
      end
      ST_STALL: begin
        if (edge_c) begin
          emit_c     = 1'b1;
          stateNxt_c = ST_TRACK;
        end
      end
      default: stateNxt_c = ST_IDLE;
    endcase
  end

  // Gap and edge counters, both saturating.
  always_ff @(posedge Bclk) begin
    if (reset) begin
      gapCnt     <= '0;
      edge_count <= '0;
    end else begin
      if (edge_c) begin
        gapCnt <= INTW'(1);
      end else if (gapCnt != GAP_SAT) begin
        gapCnt <= gapCnt + INTW'(1);
      end
      if (edge_c && (edge_count != CNT_SAT)) begin
        edge_count <= edge_count + CNTW'(1);
      end
    end
  end

  // Single-entry event buffer: a held record is never overwritten by a newer event.
  always_ff @(posedge Bclk) begin
    if (reset) begin
      evt.evt_valid    <= 1'b0;
      evt.evt_interval <= '0;
      evt.evt_level    <= 1'b0;
    end else if (emit_c && (!evt.evt_valid || evt.evt_ready)) begin
      evt.evt_valid    <= 1'b1;
      evt.evt_interval <= gapCnt;
      evt.evt_level    <= level_c;
    end else if (evt.evt_valid && evt.evt_ready) begin
      evt.evt_valid    <= 1'b0;
    end
  end

  // Sticky flags; a new error in the clearing cycle wins.
  always_ff @(posedge Bclk) begin
    if (reset) begin
      err_short    <= 1'b0;
      err_stall    <= 1'b0;
      err_overflow <= 1'b0;
    end else begin
      err_short    <= (err_short & ~clr_err) | setShort_c;
      err_stall    <= (err_stall & ~clr_err) | setStall_c;
      err_overflow <= (err_overflow & ~clr_err) | (emit_c & evt.evt_valid & ~evt.evt_ready);
    end
  end

endmodule

// File: tb/tb_cdc_toggle_monitor.sv
// Scoreboard bench for cdc_toggle_monitor: stimulus pushes expected event records,
// a negedge monitor pops and compares them on every accepted handshake.
module tb_cdc_toggle_monitor;
  import cdc_toggle_monitor_pkg::*;

  typedef struct {
    int unsigned interval;
    bit          level;
  } exp_t;

  logic                Bclk;
  logic                reset;
  logic                Din;
  logic                clr_err;
  logic [DEF_CNTW-1:0] edge_count;
  logic                err_short;
  logic                err_stall;
  logic                err_overflow;

  int   checkCnt = 0;
  int   passCnt  = 0;
  exp_t expQ[$];

  cdc_toggle_monitor_if #(.INTW(DEF_INTW)) evtIf ();

  cdc_toggle_monitor #(
    .INTW    (DEF_INTW),
    .CNTW    (DEF_CNTW),
    .MIN_GAP (DEF_MIN_GAP),
    .MAX_GAP (DEF_MAX_GAP)
  ) dut (
    .Bclk         (Bclk),
    .reset        (reset),
    .Din          (Din),
    .clr_err      (clr_err),
    .evt          (evtIf),
    .edge_count   (edge_count),
    .err_short    (err_short),
    .err_stall    (err_stall),
    .err_overflow (err_overflow)
  );

  initial Bclk = 1'b0;
  always #5 Bclk = ~Bclk;

  task automatic chk(input string name, input int act, input int exp);
    checkCnt++;
    if (act == exp) passCnt++;
    else $display("FAIL %s actual=%0d required=%0d", name, act, exp);
  endtask

  task automatic ticks(input int n);
    repeat (n) begin
      @(posedge Bclk);
      #1;
    end
  endtask

  task automatic toggleExp(input bit push, input int unsigned interval);
    Din = ~Din;
    if (push) expQ.push_back('{interval, Din});
  endtask

  // Monitor: every accepted record must match the oldest expected one.
  always @(negedge Bclk) begin
    if (!reset && evtIf.evt_valid && evtIf.evt_ready) begin
      if (expQ.size() == 0) begin
        checkCnt++;
        $display("FAIL unexpected_evt actual interval=%0d level=%0d required=none",
                 evtIf.evt_interval, evtIf.evt_level);
      end else begin
        exp_t e;
        e = expQ.pop_front();
        chk("evt_interval", int'(evtIf.evt_interval), int'(e.interval));
        chk("evt_level", int'(evtIf.evt_level), int'(e.level));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset           = 1'b1;
    Din             = 1'b0;
    clr_err         = 1'b0;
    evtIf.evt_ready = 1'b0;
    ticks(2);
    chk("rst_valid", int'(evtIf.evt_valid), 0);
    chk("rst_interval", int'(evtIf.evt_interval), 0);
    chk("rst_edge_count", int'(edge_count), 0);
    chk("rst_errs", int'({err_short, err_stall, err_overflow}), 0);
    chk("rst_state", int'(dut.state), int'(ST_IDLE));
    reset           = 1'b0;
    evtIf.evt_ready = 1'b1;

    // 1: gaps of 10 and 15, first toggle has no reference
    toggleExp(1'b0, 0);
    ticks(10);
    toggleExp(1'b1, 10);
    ticks(15);
    toggleExp(1'b1, 15);
    ticks(3);
    chk("t1_edge_count", int'(edge_count), 3);
    chk("t1_errs", int'({err_short, err_stall, err_overflow}), 0);

    // 2: gap of 1, clear, then clear coinciding with another short gap
    ticks(7);
    toggleExp(1'b1, 10);
    ticks(1);
    toggleExp(1'b1, 1);
    ticks(3);
    chk("t2_short_set", int'(err_short), 1);
    clr_err = 1'b1;
    ticks(1);
    clr_err = 1'b0;
    chk("t2_short_clr", int'(err_short), 0);
    ticks(5);
    toggleExp(1'b1, 9);
    ticks(1);
    clr_err = 1'b1;
    toggleExp(1'b1, 1);
    ticks(1);
    clr_err = 1'b0;
    ticks(2);
    chk("t2_set_wins", int'(err_short), 1);

    // 3: stall after MAX_GAP-1 silent cycles, saturated interval on resume
    ticks(7);
    toggleExp(1'b1, 10);
    ticks(DEF_MAX_GAP - 1);
    chk("t3_no_stall_yet", int'(err_stall), 0);
    chk("t3_state_track", int'(dut.state), int'(ST_TRACK));
    ticks(1);
    chk("t3_stall", int'(err_stall), 1);
    chk("t3_state_stall", int'(dut.state), int'(ST_STALL));
    ticks(90);
    toggleExp(1'b1, 255);
    ticks(3);
    chk("t3_state_back", int'(dut.state), int'(ST_TRACK));
    chk("t3_stall_sticky", int'(err_stall), 1);

    // 4: overflow with reader stalled, then accept and reload in the same cycle
    clr_err = 1'b1;
    ticks(1);
    clr_err = 1'b0;
    chk("t4_errs_cleared", int'({err_short, err_stall, err_overflow}), 0);
    evtIf.evt_ready = 1'b0;
    ticks(1);
    toggleExp(1'b1, 5);
    ticks(7);
    toggleExp(1'b0, 0);
    ticks(2);
    chk("t4_held_valid", int'(evtIf.evt_valid), 1);
    chk("t4_held_interval", int'(evtIf.evt_interval), 5);
    chk("t4_overflow", int'(err_overflow), 1);
    ticks(4);
    evtIf.evt_ready = 1'b1;
    toggleExp(1'b1, 6);
    ticks(1);
    chk("t4_reload_valid", int'(evtIf.evt_valid), 1);
    chk("t4_reload_interval", int'(evtIf.evt_interval), 6);
    ticks(3);
    chk("t4_drained", int'(evtIf.evt_valid), 0);

    // 5: reset while a record is pending and Din is high
    evtIf.evt_ready = 1'b0;
    ticks(1);
    toggleExp(1'b0, 0);
    ticks(3);
    chk("t5_pending", int'(evtIf.evt_valid), 1);
    chk("t5_din_high", int'(Din), 1);
    reset = 1'b1;
    ticks(1);
    reset = 1'b0;
    chk("t5_valid", int'(evtIf.evt_valid), 0);
    chk("t5_edge_count", int'(edge_count), 0);
    chk("t5_errs", int'({err_short, err_stall, err_overflow}), 0);
    chk("t5_state_idle", int'(dut.state), int'(ST_IDLE));
    ticks(3);
    chk("t5_no_false_edge", int'(edge_count), 0);
    chk("t5_still_idle", int'(dut.state), int'(ST_IDLE));
    evtIf.evt_ready = 1'b1;
    toggleExp(1'b0, 0);
    ticks(3);
    chk("t5_first_no_evt", int'(evtIf.evt_valid), 0);
    chk("t5_edge_one", int'(edge_count), 1);
    chk("t5_state_track", int'(dut.state), int'(ST_TRACK));
    ticks(1);
    toggleExp(1'b1, 4);
    ticks(3);
    chk("t5_edge_two", int'(edge_count), 2);

    chk("pending_expected", expQ.size(), 0);
    $display("%0d/%0d checks passed", passCnt, checkCnt);
    $finish;
  end

endmodule
